adder_arbiter: RTL and testbench

- Shares one combinational adder_32bit instance among NUM_REQ requesters.
- Each requester presents an operand pair on a valid/ready request channel. A round-robin arbiter grants one requester at a time and registers its operands. The sum is then returned on a single shared response channel, tagged with the requester ID, under valid/ready backpressure.
- Sits between the AXI register front-end / accelerator clients and the adder datapath.

---
 rtl/adder_arbiter_pkg.sv | 21 ++
 rtl/adder_32bit.sv | 11 +
 rtl/rr_arbiter.sv | 31 +++
 rtl/adder_arbiter.sv | 134 +++++++++++++
 tb/tb_adder_arbiter.sv | 297 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/adder_arbiter_pkg.sv
// Shared constants and helpers for the arbitrated adder.
// Holds the FSM encodings and the operand width.
package adder_arbiter_pkg;

    localparam int DATA_W = 32;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_EXEC = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    // Carry out of bit 31, recovered from the operands and the sum MSB.
    function automatic logic carry_msb(
        input logic [DATA_W-1:0] a,
        input logic [DATA_W-1:0] b,
        input logic [DATA_W-1:0] s
    );
        return (a[DATA_W-1] & b[DATA_W-1]) |
               ((a[DATA_W-1] | b[DATA_W-1]) & ~s[DATA_W-1]);
    endfunction

endpackage

// File: rtl/adder_32bit.sv
// Plain combinational 32-bit adder, sum modulo 2^32.
// Shared datapath resource behind the arbiter.
module adder_32bit (
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] s
);

    assign s = a + b;

endmodule

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: searches upward from
// last_grant+1 with wrap-around and returns a one-hot grant.
module rr_arbiter #(
    parameter int N   = 4,
    parameter int IDW = 2
) (
    input  logic [N-1:0]   req,
    input  logic [IDW-1:0] last_grant,
    output logic [N-1:0]   grant,
    output logic [IDW-1:0] grant_id,
    output logic           found
);

    int idx;

    always_comb begin
        grant    = '0;
        grant_id = '0;
        found    = 1'b0;
        idx      = 0;
        for (int k = 1; k <= N; k++) begin
            idx = (int'(last_grant) + k) % N;
            if (!found && req[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                grant_id   = IDW'(idx);
            end
        end
    end

endmodule

// File: rtl/adder_arbiter.sv
// Shares one adder among NUM_REQ requesters: round-robin grant,
// one registered execute cycle, tagged response under backpressure.
module adder_arbiter
    import adder_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [NUM_REQ*DATA_W-1:0] req_a,
    input  logic [NUM_REQ*DATA_W-1:0] req_b,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [ID_W-1:0]           rsp_id,
    output logic [DATA_W-1:0]         rsp_sum,
    output logic                      rsp_carry,
    output logic                      busy
);

    logic [1:0]        state_q, state_d;
    logic [DATA_W-1:0] op_a_q, op_a_d;
    logic [DATA_W-1:0] op_b_q, op_b_d;
    logic [ID_W-1:0]   op_id_q, op_id_d;
    logic [ID_W-1:0]   last_q, last_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0] rsp_sum_q, rsp_sum_d;
    logic              rsp_carry_q, rsp_carry_d;
    logic [ID_W-1:0]   rsp_id_q, rsp_id_d;

    logic [NUM_REQ-1:0] grant;
    logic [ID_W-1:0]    grant_id;
    logic               found;
    logic [DATA_W-1:0]  sel_a, sel_b, sum;

    rr_arbiter #(
        .N   (NUM_REQ),
        .IDW (ID_W)
    ) u_arb (
        .req        (req_valid),
        .last_grant (last_q),
        .grant      (grant),
        .grant_id   (grant_id),
        .found      (found)
    );

    adder_32bit u_add (
        .a (op_a_q),
        .b (op_b_q),
        .s (sum)
    );

    always_comb begin
        sel_a = '0;
        sel_b = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                sel_a = req_a[i*DATA_W +: DATA_W];
                sel_b = req_b[i*DATA_W +: DATA_W];
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        op_a_d      = op_a_q;
        op_b_d      = op_b_q;
        op_id_d     = op_id_q;
        last_d      = last_q;
        rsp_valid_d = rsp_valid_q;
        rsp_sum_d   = rsp_sum_q;
        rsp_carry_d = rsp_carry_q;
        rsp_id_d    = rsp_id_q;
        unique case (state_q)
            S_IDLE: begin
                if (found) begin
                    op_a_d  = sel_a;
                    op_b_d  = sel_b;
                    op_id_d = grant_id;
                    last_d  = grant_id;
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                rsp_sum_d   = sum;
                rsp_carry_d = carry_msb(op_a_q, op_b_q, sum);
                rsp_id_d    = op_id_q;
                rsp_valid_d = 1'b1;
                state_d     = S_RESP;
            end
            S_RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            op_a_q      <= '0;
            op_b_q      <= '0;
            op_id_q     <= '0;
            last_q      <= ID_W'(NUM_REQ - 1);
            rsp_valid_q <= 1'b0;
            rsp_sum_q   <= '0;
            rsp_carry_q <= 1'b0;
            rsp_id_q    <= '0;
        end else begin
            state_q     <= state_d;
            op_a_q      <= op_a_d;
            op_b_q      <= op_b_d;
            op_id_q     <= op_id_d;
            last_q      <= last_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_sum_q   <= rsp_sum_d;
            rsp_carry_q <= rsp_carry_d;
            rsp_id_q    <= rsp_id_d;
        end
    end

    assign req_ready = (state_q == S_IDLE) ? grant : '0;
    assign busy      = (state_q != S_IDLE);
    assign rsp_valid = rsp_valid_q;
    assign rsp_sum   = rsp_sum_q;
    assign rsp_carry = rsp_carry_q;
    assign rsp_id    = rsp_id_q;

endmodule

// File: tb/tb_adder_arbiter.sv
// Directed vector table, multi-cycle corner sequences and a
// random soak against a queue-based reference for adder_arbiter.
module tb_adder_arbiter;

    localparam int N = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic [N-1:0]      req_valid;
    logic [N-1:0]      req_ready;
    logic [N*32-1:0]   req_a;
    logic [N*32-1:0]   req_b;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [1:0]        rsp_id;
    logic [31:0]       rsp_sum;
    logic              rsp_carry;
    logic              busy;

    int checks = 0;
    int fails  = 0;

    typedef struct {
        int          id;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] sum;
        logic        carry;
    } vec_t;

    typedef struct {
        int          id;
        logic [31:0] sum;
        logic        carry;
    } exp_t;

    vec_t vecs[7];
    exp_t expq[$];

    adder_arbiter #(.NUM_REQ(N), .ID_W(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_sum   (rsp_sum),
        .rsp_carry (rsp_carry),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #3000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        req_valid = '0;
        rsp_ready = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic wait_grant(input int id, output bit ok);
        ok = 1'b0;
        for (int n = 0; n < 20 && !ok; n++) begin
            #1;
            if (req_ready[id]) ok = 1'b1;
            else step();
        end
        if (!ok) chk($sformatf("grant%0d_timeout", id), 0, 1);
    endtask

    task automatic wait_any(output bit ok);
        ok = 1'b0;
        for (int n = 0; n < 20 && !ok; n++) begin
            #1;
            if (|req_ready) ok = 1'b1;
            else step();
        end
        if (!ok) chk("grant_any_timeout", 0, 1);
    endtask

    task automatic set_ops(input int i, input logic [31:0] a,
                           input logic [31:0] b);
        req_a[32*i +: 32] = a;
        req_b[32*i +: 32] = b;
    endtask

    initial begin
        bit ok;
        int order[5];
        bit pend[N];
        bit acc[N];
        int waits[N];
        logic [31:0] pa[N];
        logic [31:0] pb[N];
        int accepts;
        int resps;

        vecs[0] = '{2, 32'h0000_0005, 32'h0000_0007, 32'h0000_000C, 1'b0};
        vecs[1] = '{0, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b1};
        vecs[2] = '{1, 32'h8000_0000, 32'h8000_0000, 32'h0000_0000, 1'b1};
        vecs[3] = '{3, 32'h1234_5678, 32'h8765_4321, 32'h9999_9999, 1'b0};
        vecs[4] = '{0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b1};
        vecs[5] = '{2, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 1'b0};
        vecs[6] = '{1, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 1'b0};
        order   = '{0, 1, 2, 3, 0};

        req_a = '0;
        req_b = '0;
        do_reset();
        #1;
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_req_ready", req_ready, 0);
        chk("rst_rsp_sum", rsp_sum, 0);
        chk("rst_rsp_id", rsp_id, 0);
        chk("rst_rsp_carry", rsp_carry, 0);

        for (int k = 0; k < 7; k++) begin
            req_valid = '0;
            req_valid[vecs[k].id] = 1'b1;
            set_ops(vecs[k].id, vecs[k].a, vecs[k].b);
            wait_grant(vecs[k].id, ok);
            if (ok) begin
                chk($sformatf("v%0d_ready", k), req_ready,
                    64'(1) << vecs[k].id);
                step();
                req_valid = '0;
                #1;
                chk($sformatf("v%0d_exec_valid", k), rsp_valid, 0);
                chk($sformatf("v%0d_exec_ready", k), req_ready, 0);
                chk($sformatf("v%0d_exec_busy", k), busy, 1);
                step();
                #1;
                chk($sformatf("v%0d_valid", k), rsp_valid, 1);
                chk($sformatf("v%0d_sum", k), rsp_sum, vecs[k].sum);
                chk($sformatf("v%0d_carry", k), rsp_carry, vecs[k].carry);
                chk($sformatf("v%0d_id", k), rsp_id, vecs[k].id);
                step();
                #1;
                chk($sformatf("v%0d_done_valid", k), rsp_valid, 0);
                chk($sformatf("v%0d_done_busy", k), busy, 0);
            end
        end

        do_reset();
        for (int i = 0; i < N; i++) set_ops(i, i, 32'h100 * i);
        req_valid = '1;
        for (int g = 0; g < 5; g++) begin
            wait_any(ok);
            if (ok) begin
                chk($sformatf("rr%0d_grant", g), req_ready,
                    64'(1) << order[g]);
                step();
                #1;
                step();
                #1;
                chk($sformatf("rr%0d_valid", g), rsp_valid, 1);
                chk($sformatf("rr%0d_id", g), rsp_id, order[g]);
                chk($sformatf("rr%0d_sum", g), rsp_sum, 32'h101 * order[g]);
                step();
            end
        end

        do_reset();
        req_valid    = '0;
        req_valid[1] = 1'b1;
        set_ops(1, 32'h11, 32'h22);
        rsp_ready = 1'b0;
        wait_grant(1, ok);
        step();
        req_valid = '1;
        #1;
        step();
        #1;
        for (int c = 0; c < 5; c++) begin
            chk($sformatf("bp%0d_valid", c), rsp_valid, 1);
            chk($sformatf("bp%0d_sum", c), rsp_sum, 32'h33);
            chk($sformatf("bp%0d_id", c), rsp_id, 1);
            chk($sformatf("bp%0d_ready", c), req_ready, 0);
            chk($sformatf("bp%0d_busy", c), busy, 1);
            step();
            #1;
        end
        rsp_ready = 1'b1;
        step();
        #1;
        chk("bp_rel_valid", rsp_valid, 0);
        chk("bp_rel_busy", busy, 0);
        chk("bp_rel_next_grant", req_ready, 4'b0100);

        do_reset();
        for (int i = 0; i < N; i++) set_ops(i, 32'hA0 + i, 32'h5);
        req_valid = '1;
        wait_grant(0, ok);
        step();
        #1;
        chk("mid_exec_busy", busy, 1);
        rst = 1'b1;
        #1;
        chk("mid_rst_valid", rsp_valid, 0);
        chk("mid_rst_busy", busy, 0);
        step();
        rst = 1'b0;
        #1;
        chk("mid_first_grant", req_ready, 4'b0001);
        step();
        #1;
        chk("mid_no_rsp", rsp_valid, 0);

        do_reset();
        accepts = 0;
        resps   = 0;
        expq.delete();
        for (int i = 0; i < N; i++) begin
            pend[i]  = 1'b0;
            acc[i]   = 1'b0;
            waits[i] = 0;
        end
        for (int cyc = 0; cyc < 8040; cyc++) begin
            step();
            for (int i = 0; i < N; i++) begin
                if (acc[i]) begin
                    pend[i] = 1'b0;
                    acc[i]  = 1'b0;
                end
                if (cyc < 8000 && !pend[i] && $urandom_range(0, 3) == 0) begin
                    pend[i] = 1'b1;
                    pa[i] = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFF : $urandom;
                    pb[i] = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : $urandom;
                end
                req_valid[i] = pend[i];
                set_ops(i, pa[i], pb[i]);
            end
            rsp_ready = (cyc >= 8000) ? 1'b1 : ($urandom_range(0, 2) != 0);
            #1;
            chk("soak_onehot", $onehot0(req_ready), 1);
            for (int i = 0; i < N; i++) begin
                if (req_ready[i]) begin
                    logic [32:0] t;
                    t = {1'b0, pa[i]} + {1'b0, pb[i]};
                    chk("soak_ready_valid", req_valid[i], 1);
                    chk("soak_fair", waits[i] < N, 1);
                    expq.push_back('{i, t[31:0], t[32]});
                    accepts++;
                    acc[i]   = 1'b1;
                    waits[i] = 0;
                    for (int j = 0; j < N; j++)
                        if (j != i && pend[j]) waits[j]++;
                end
            end
            if (rsp_valid && rsp_ready) begin
                resps++;
                if (expq.size() == 0) begin
                    chk("soak_dup_rsp", 0, 1);
                end else begin
                    exp_t e;
                    e = expq.pop_front();
                    chk("soak_sum", rsp_sum, e.sum);
                    chk("soak_carry", rsp_carry, e.carry);
                    chk("soak_id", rsp_id, e.id);
                end
            end
        end
        chk("soak_count", resps, accepts);
        chk("soak_lost", expq.size(), 0);
        chk("soak_activity", accepts > 500, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
